// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART receiver: FSM states, parity
// mode constants and the oversampling divisor calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    BRK
  } rxState_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Rounded clk/(baud*oversample), computed in 64 bits so large clocks cannot overflow.
  function automatic int calcDivisor(input int clkHz, input int baud, input int overSample);
    longint denom;
    denom = longint'(baud) * longint'(overSample);
    return int'((longint'(clkHz) + denom / 2) / denom);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; a write is accepted while full only if a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush, doPop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_COUNT);
  assign doPop  = rd_en & ~empty;
  assign doPush = wr_en & (~full | doPop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      if (doPush && !doPop)      count_q <= count_q + (AW + 1)'(1);
      else if (doPop && !doPush) count_q <= count_q - (AW + 1)'(1);
    end
  end

  // Storage carries no reset; consumers gate the head with empty.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wr_data;
  end

  assign rd_data = mem_q[rdPtr_q];
  assign count   = count_q;

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: synchroniser, tick divider, majority-vote bit FSM
// and a tagged receive FIFO with sticky overrun.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic                          rx_valid,
  output logic [7:0]                    rx_data,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic [7:0]                    LEDG
);

  localparam int DIV = calcDivisor(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DW  = $clog2(DIV + 1);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int EW  = DATA_BITS + 2;
  localparam logic [DW-1:0] DIV_END   = DW'(DIV - 1);
  localparam logic [SW-1:0] S_LO      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI      = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END     = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  logic [1:0]           sync_q;
  logic [1:0]           settle_q;
  logic                 rxPrev_q;
  logic                 rxS, fallEdge, tick, vote, expBit, ferrNow;
  logic [DW-1:0]        divCnt_q;
  logic [SW-1:0]        sampCnt_q;
  logic                 s0_q, s1_q;
  rxState_e             state_q;
  logic [2:0]           bitCnt_q;
  logic                 stopCnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parErr_q, frmErr_q;
  logic                 push_q;
  logic [EW-1:0]        pushEntry_q;
  logic [7:0]           ledg_q;
  logic                 overrun_q;
  logic [EW-1:0]        head;
  logic                 fifoFull, fifoEmpty;

  assign rxS = sync_q[1];

  // rxPrev is held low until the synchroniser holds a real line sample, so a
  // line that is already low when reset releases never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= 2'b11;
      settle_q <= '0;
      rxPrev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx};
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      rxPrev_q <= (settle_q == 2'd2) ? rxS : 1'b0;
    end
  end

  assign fallEdge = rxPrev_q & ~rxS;
  assign tick     = (divCnt_q == DIV_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              divCnt_q <= '0;
    else if ((state_q == IDLE && fallEdge) || tick) divCnt_q <= '0;
    else                                  divCnt_q <= divCnt_q + DW'(1);
  end

  assign vote    = (s0_q & s1_q) | (s0_q & rxS) | (s1_q & rxS);
  assign expBit  = (PARITY == PARITY_ODD) ? ~(^shift_q) : (^shift_q);
  assign ferrNow = frmErr_q | ~vote;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sampCnt_q   <= '0;
      s0_q        <= 1'b0;
      s1_q        <= 1'b0;
      bitCnt_q    <= '0;
      stopCnt_q   <= 1'b0;
      shift_q     <= '0;
      parErr_q    <= 1'b0;
      frmErr_q    <= 1'b0;
      push_q      <= 1'b0;
      pushEntry_q <= '0;
    end else begin
      push_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fallEdge) begin
            state_q   <= START;
            sampCnt_q <= '0;
            bitCnt_q  <= '0;
            stopCnt_q <= 1'b0;
            parErr_q  <= 1'b0;
            frmErr_q  <= 1'b0;
          end
        end
        BRK: begin
          if (rxS) state_q <= IDLE;
        end
        default: begin
          if (tick) begin
            sampCnt_q <= (sampCnt_q == S_END) ? '0 : sampCnt_q + SW'(1);
            if (sampCnt_q == S_LO)  s0_q <= rxS;
            if (sampCnt_q == S_MID) s1_q <= rxS;
            if (sampCnt_q == S_HI) begin
              case (state_q)
                START: if (vote) state_q <= IDLE;
                DATA:  shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                PAR:   parErr_q <= (vote != expBit);
                STOP: begin
                  if (!vote) frmErr_q <= 1'b1;
                  // The frame ends at the last stop vote so the next start edge is never missed.
                  if (stopCnt_q == STOP_LAST) begin
                    push_q      <= 1'b1;
                    pushEntry_q <= {parErr_q, ferrNow, shift_q};
                    state_q     <= (ferrNow && shift_q == '0) ? BRK : IDLE;
                  end
                end
                default: ;
              endcase
            end
            if (sampCnt_q == S_END) begin
              case (state_q)
                START: state_q <= DATA;
                DATA: begin
                  if (bitCnt_q == LAST_BIT) state_q <= (PARITY != PARITY_NONE) ? PAR : STOP;
                  else                      bitCnt_q <= bitCnt_q + 3'd1;
                end
                PAR:  state_q <= STOP;
                STOP: stopCnt_q <= stopCnt_q + 1'b1;
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_q),
    .wr_data (pushEntry_q),
    .rd_en   (rd_en),
    .rd_data (head),
    .full    (fifoFull),
    .empty   (fifoEmpty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ledg_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push_q) ledg_q <= 8'(pushEntry_q[DATA_BITS-1:0]);
      if (push_q && fifoFull && !(rd_en && !fifoEmpty)) overrun_q <= 1'b1;
      else if (clr_err)                                 overrun_q <= 1'b0;
    end
  end

  assign rx_valid   = ~fifoEmpty;
  assign rx_data    = fifoEmpty ? 8'h00 : 8'(head[DATA_BITS-1:0]);
  assign frame_err  = ~fifoEmpty & head[DATA_BITS];
  assign parity_err = ~fifoEmpty & head[DATA_BITS+1];
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);
  assign LEDG       = ledg_q;

endmodule
